// File: rtl/hart_request_arbiter.sv
// hart_request_arbiter
//
// Shares one hart request buffer among N_HARTS harts. Each cycle in which the
// output holding register is free, one valid hart is granted. Its request is
// captured into the holding register, which drives the buffer write port
// tagged with the owning hart index.
//
// Arbitration policy:
//   default                      round-robin, starting after the last granted hart
//   HART_ARB_FIXED_PRIORITY_EN   fixed priority, lowest-index valid hart wins
//
// Ports:
//   clock_i      rising-edge clock
//   reset_i      synchronous, active-high reset
//   req_valid_i  per-hart request valid
//   req_wren_i   per-hart write enable (1 = store)
//   req_addr_i   flattened addresses, hart h at [h*BW_ADDR +: BW_ADDR]
//   req_data_i   flattened store data, same packing
//   req_ack_o    one-hot combinational ack, high in the capture cycle
//   buf_write_o  write strobe to the buffer (holding register valid)
//   buf_wren_o   captured write enable
//   buf_addr_o   captured address
//   buf_data_o   captured data
//   buf_hart_o   index of the hart owning the captured request
//   buf_full_i   buffer full back-pressure
module hart_request_arbiter #(
  parameter int unsigned N_HARTS = 4,
  parameter int unsigned BW_ADDR = 32,
  parameter int unsigned BW_DATA = 32
) (
  input  logic                         clock_i,
  input  logic                         reset_i,
  input  logic [N_HARTS-1:0]           req_valid_i,
  input  logic [N_HARTS-1:0]           req_wren_i,
  input  logic [N_HARTS*BW_ADDR-1:0]   req_addr_i,
  input  logic [N_HARTS*BW_DATA-1:0]   req_data_i,
  output logic [N_HARTS-1:0]           req_ack_o,
  output logic                         buf_write_o,
  output logic                         buf_wren_o,
  output logic [BW_ADDR-1:0]           buf_addr_o,
  output logic [BW_DATA-1:0]           buf_data_o,
  output logic [$clog2(N_HARTS)-1:0]   buf_hart_o,
  input  logic                         buf_full_i
);

  localparam int unsigned BW_HART = $clog2(N_HARTS);

  logic               hold_valid_q, hold_valid_d;
  logic               hold_wren_q,  hold_wren_d;
  logic [BW_ADDR-1:0] hold_addr_q,  hold_addr_d;
  logic [BW_DATA-1:0] hold_data_q,  hold_data_d;
  logic [BW_HART-1:0] hold_hart_q,  hold_hart_d;

  logic               accept;
  logic               free;
  logic               grant;
  logic               grant_found;
  logic [BW_HART-1:0] grant_idx;

  // The buffer takes the held entry at this edge, so the register can reload.
  assign accept = hold_valid_q & ~buf_full_i;
  assign free   = ~hold_valid_q | accept;
  // Acks are suppressed while reset is asserted: the capture would be discarded.
  assign grant  = free & grant_found & ~reset_i;

`ifdef HART_ARB_FIXED_PRIORITY_EN

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int unsigned i = 0; i < N_HARTS; i++) begin
      if (!grant_found && req_valid_i[i]) begin
        grant_found = 1'b1;
        grant_idx   = BW_HART'(i);
      end
    end
  end

`else

  logic [BW_HART-1:0] last_grant_q, last_grant_d;
  logic [BW_HART-1:0] cand;

  // Scan upward from last_grant+1; the index wraps naturally because
  // N_HARTS is a power of two. The final step (i == N_HARTS) revisits
  // last_grant itself, so a lone valid hart is granted every time.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned i = 1; i <= N_HARTS; i++) begin
      cand = last_grant_q + BW_HART'(i);
      if (!grant_found && req_valid_i[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (grant) begin
      last_grant_d = grant_idx;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      last_grant_q <= BW_HART'(N_HARTS - 1);
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

`endif

  always_comb begin
    req_ack_o = '0;
    if (grant) begin
      req_ack_o[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_wren_d  = hold_wren_q;
    hold_addr_d  = hold_addr_q;
    hold_data_d  = hold_data_q;
    hold_hart_d  = hold_hart_q;
    if (free) begin
      hold_valid_d = grant;
      if (grant) begin
        hold_wren_d = req_wren_i[grant_idx];
        hold_addr_d = req_addr_i[grant_idx * BW_ADDR +: BW_ADDR];
        hold_data_d = req_data_i[grant_idx * BW_DATA +: BW_DATA];
        hold_hart_d = grant_idx;
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      hold_valid_q <= 1'b0;
      hold_wren_q  <= 1'b0;
      hold_addr_q  <= '0;
      hold_data_q  <= '0;
      hold_hart_q  <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_wren_q  <= hold_wren_d;
      hold_addr_q  <= hold_addr_d;
      hold_data_q  <= hold_data_d;
      hold_hart_q  <= hold_hart_d;
    end
  end

  assign buf_write_o = hold_valid_q;
  assign buf_wren_o  = hold_wren_q;
  assign buf_addr_o  = hold_addr_q;
  assign buf_data_o  = hold_data_q;
  assign buf_hart_o  = hold_hart_q;

endmodule

// File: tb/tb_hart_request_arbiter.sv
module tb_hart_request_arbiter;

  localparam int N  = 4;
  localparam int BA = 32;
  localparam int BD = 32;
  localparam int BH = 2;

  logic            clock;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_wren;
  logic [N*BA-1:0] req_addr;
  logic [N*BD-1:0] req_data;
  logic [N-1:0]    ack;
  logic            buf_write;
  logic            buf_wren;
  logic [BA-1:0]   buf_addr;
  logic [BD-1:0]   buf_data;
  logic [BH-1:0]   buf_hart;
  logic            buf_full;

  int checks   = 0;
  int failures = 0;

  hart_request_arbiter #(
    .N_HARTS (N),
    .BW_ADDR (BA),
    .BW_DATA (BD)
  ) dut (
    .clock_i     (clock),
    .reset_i     (reset),
    .req_valid_i (req_valid),
    .req_wren_i  (req_wren),
    .req_addr_i  (req_addr),
    .req_data_i  (req_data),
    .req_ack_o   (ack),
    .buf_write_o (buf_write),
    .buf_wren_o  (buf_wren),
    .buf_addr_o  (buf_addr),
    .buf_data_o  (buf_data),
    .buf_hart_o  (buf_hart),
    .buf_full_i  (buf_full)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit           rst;
    logic [N-1:0] valid;
    bit           full;
    logic [N-1:0] exp_ack;
    bit           exp_write;
    int           exp_hart;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(bit rst, logic [N-1:0] v, bit f, logic [N-1:0] a, bit w, int h);
    vec_t r;
    r.rst = rst; r.valid = v; r.full = f; r.exp_ack = a; r.exp_write = w; r.exp_hart = h;
    vecs.push_back(r);
  endfunction

  function automatic logic [BA-1:0] fix_addr(int h);
    return BA'(h * 32'h1000);
  endfunction

  function automatic logic [BD-1:0] fix_data(int h);
    return 32'hDEAD_BEEC + BD'(h);
  endfunction

  // ---------------- behavioural reference model ----------------
  bit           m_valid;
  int           m_hart;
  logic [BA-1:0] m_addr;
  logic [BD-1:0] m_data;
  bit           m_wren;
  int           m_last;

  function automatic int model_pick(logic [N-1:0] v);
`ifdef HART_ARB_FIXED_PRIORITY_EN
    for (int h = 0; h < N; h++) if (v[h]) return h;
`else
    for (int k = 1; k <= N; k++) begin
      int h;
      h = (m_last + k) % N;
      if (v[h]) return h;
    end
`endif
    return -1;
  endfunction

  task automatic model_eval(output logic [N-1:0] ea, output int p);
    ea = '0;
    p  = -1;
    if (!reset && (!m_valid || !buf_full)) begin
      p = model_pick(req_valid);
      if (p >= 0) ea[p] = 1'b1;
    end
  endtask

  task automatic model_edge();
    logic [N-1:0] ea;
    int p;
    model_eval(ea, p);
    if (reset) begin
      m_valid = 0; m_hart = 0; m_addr = '0; m_data = '0; m_wren = 0; m_last = N - 1;
    end else if (!m_valid || !buf_full) begin
      if (p >= 0) begin
        m_valid = 1;
        m_hart  = p;
        m_addr  = req_addr[p*BA +: BA];
        m_data  = req_data[p*BD +: BD];
        m_wren  = req_wren[p];
        m_last  = p;
      end else begin
        m_valid = 0;
      end
    end
  endtask

  bit pend[N];
  int wait_g[N];

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_wren  = '0;
    req_addr  = '0;
    req_data  = '0;
    buf_full  = 1'b0;
    for (int h = 0; h < N; h++) begin
      req_addr[h*BA +: BA] = fix_addr(h);
      req_data[h*BD +: BD] = fix_data(h);
      req_wren[h]          = h[0];
    end

`ifdef HART_ARB_FIXED_PRIORITY_EN
    add(1, 4'b0101, 0, 4'b0000, 0, 0);
    add(1, 4'b0101, 0, 4'b0000, 0, 0);
    add(0, 4'b0101, 0, 4'b0001, 0, 0);
    add(0, 4'b0101, 0, 4'b0001, 1, 0);
    add(0, 4'b0101, 0, 4'b0001, 1, 0);
    add(0, 4'b0101, 1, 4'b0000, 1, 0);
    add(0, 4'b0101, 0, 4'b0001, 1, 0);
    add(0, 4'b0101, 0, 4'b0001, 1, 0);
`else
    // reset with all harts valid
    add(1, 4'b1111, 0, 4'b0000, 0, 0);
    add(1, 4'b1111, 0, 4'b0000, 0, 0);
    // round robin, back-to-back
    add(0, 4'b1111, 0, 4'b0001, 0, 0);
    add(0, 4'b1111, 0, 4'b0010, 1, 0);
    add(0, 4'b1111, 0, 4'b0100, 1, 1);
    add(0, 4'b1111, 0, 4'b1000, 1, 2);
    add(0, 4'b1111, 0, 4'b0001, 1, 3);
    add(0, 4'b1111, 0, 4'b0010, 1, 0);
    // five cycles of back-pressure holding hart 1
    for (int i = 0; i < 5; i++) add(0, 4'b1111, 1, 4'b0000, 1, 1);
    // full falls: same-cycle ack of the next hart
    add(0, 4'b1111, 0, 4'b0100, 1, 1);
    add(0, 4'b1111, 0, 4'b1000, 1, 2);
    // sparse harts 1 and 3, last grant was 3
    add(0, 4'b1010, 0, 4'b0010, 1, 3);
    add(0, 4'b1010, 0, 4'b1000, 1, 1);
    add(0, 4'b1010, 0, 4'b0010, 1, 3);
    add(0, 4'b1010, 0, 4'b1000, 1, 1);
    // reset mid-stall
    add(0, 4'b1010, 1, 4'b0000, 1, 3);
    add(1, 4'b1111, 1, 4'b0000, 1, 3);
    add(0, 4'b1111, 1, 4'b0001, 0, 0);
    add(0, 4'b1111, 0, 4'b0010, 1, 0);
    // idle drains the holding register
    add(0, 4'b0000, 0, 4'b0000, 1, 1);
    add(0, 4'b0000, 0, 4'b0000, 0, 0);
`endif

    @(posedge clock); #1;
    foreach (vecs[i]) begin
      reset     = vecs[i].rst;
      req_valid = vecs[i].valid;
      buf_full  = vecs[i].full;
      #4;
      chk($sformatf("vec%0d_ack", i), 64'(ack), 64'(vecs[i].exp_ack));
      chk($sformatf("vec%0d_write", i), 64'(buf_write), 64'(vecs[i].exp_write));
      if (vecs[i].exp_write) begin
        chk($sformatf("vec%0d_hart", i), 64'(buf_hart), 64'(vecs[i].exp_hart));
        chk($sformatf("vec%0d_addr", i), 64'(buf_addr), 64'(fix_addr(vecs[i].exp_hart)));
        chk($sformatf("vec%0d_data", i), 64'(buf_data), 64'(fix_data(vecs[i].exp_hart)));
        chk($sformatf("vec%0d_wren", i), 64'(buf_wren), 64'(vecs[i].exp_hart % 2));
      end else if (vecs[i].rst) begin
        chk($sformatf("vec%0d_rst_fields", i), {buf_addr, buf_data}, 64'h0);
        chk($sformatf("vec%0d_rst_hw", i), 64'({buf_hart, buf_wren}), 64'h0);
      end
      @(posedge clock); #1;
    end

    // ---------------- randomized run against the model ----------------
    for (int h = 0; h < N; h++) begin
      pend[h]   = 0;
      wait_g[h] = 0;
    end
    for (int cyc = 0; cyc < 2000; cyc++) begin
      logic [N-1:0] ea;
      int p;
      reset    = (cyc == 0) || ($urandom_range(0, 149) == 0);
      buf_full = ($urandom_range(0, 2) == 0);
      for (int h = 0; h < N; h++) begin
        if (!pend[h]) begin
          req_addr[h*BA +: BA] = $urandom;
          req_data[h*BD +: BD] = $urandom;
          req_wren[h]          = 1'($urandom_range(0, 1));
          if ($urandom_range(0, 3) != 0) pend[h] = 1;
        end
        req_valid[h] = pend[h];
      end
      #4;
      model_eval(ea, p);
      if (cyc != 0) begin
        chk($sformatf("rnd%0d_ack", cyc), 64'(ack), 64'(ea));
        chk($sformatf("rnd%0d_write", cyc), 64'(buf_write), 64'(m_valid));
        if (m_valid) begin
          chk($sformatf("rnd%0d_hart", cyc), 64'(buf_hart), 64'(m_hart));
          chk($sformatf("rnd%0d_addr", cyc), 64'(buf_addr), 64'(m_addr));
          chk($sformatf("rnd%0d_data", cyc), 64'(buf_data), 64'(m_data));
          chk($sformatf("rnd%0d_wren", cyc), 64'(buf_wren), 64'(m_wren));
        end
      end
      if (p >= 0) begin
`ifndef HART_ARB_FIXED_PRIORITY_EN
        checks++;
        if (wait_g[p] > N - 1) begin
          failures++;
          $display("FAIL rnd%0d_fair: hart %0d waited %0d grants, required at most %0d",
                   cyc, p, wait_g[p], N - 1);
        end
`endif
        for (int h = 0; h < N; h++) if (h != p && req_valid[h]) wait_g[h]++;
        wait_g[p] = 0;
        pend[p]   = 0;
      end
      model_edge();
      if (reset) for (int h = 0; h < N; h++) wait_g[h] = 0;
      @(posedge clock); #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hart_request_arbiter.md
# hart_request_arbiter

Round-robin arbiter that shares one hart request buffer among `N_HARTS` requesting harts. It accepts one request per cycle from the highest-priority valid hart and captures it in a single output holding register. From that register it drives the buffer's write port, tagged with the granting hart's index. It sits between the hart load/store ports and the request buffer, and honours the buffer's `full` back-pressure.

## Interface
- `N_HARTS`, 4, number of requesting harts (power of two, ≥2)
- `BW_ADDR`, 32, request address width
- `BW_DATA`, 32, request data width
- `BW_HART`, `CLOG2(N_HARTS)`, hart-index width (localparam)

Ports:
- `clock_i`  in  1  single clock; all state updates on the rising edge
- `reset_i`  in  1  reset, synchronous, active-high
- `req_valid_i`  in  N_HARTS  per-hart request valid
- `req_wren_i`  in  N_HARTS  per-hart write-enable (1 = store, 0 = load)
- `req_addr_i`  in  N_HARTS*BW_ADDR  flattened addresses, hart h at `[h*BW_ADDR +: BW_ADDR]`
- `req_data_i`  in  N_HARTS*BW_DATA  flattened store data, same packing
- `req_ack_o`  out  N_HARTS  one-hot, combinational; high in the cycle hart h's request is captured
- `buf_write_o`  out  1  write strobe to the request buffer (= holding register valid)
- `buf_wren_o`  out  1  captured wren
- `buf_addr_o`  out  BW_ADDR  captured address
- `buf_data_o`  out  BW_DATA  captured data
- `buf_hart_o`  out  BW_HART  index of the hart that owns the captured request
- `buf_full_i`  in  1  request buffer full

## Operation
- **Holding register:** `hold_valid`, plus the captured wren, addr, data and hart fields.
- **Accept:** `accept = hold_valid & !buf_full_i`. The buffer consumes the entry at this edge.
- **Free:** `free = !hold_valid | accept`.
- **Grant:**
  - When `free` and any `req_valid_i` bit is set, pick the first valid hart scanning upward from `(last_grant + 1) mod N_HARTS`.
  - Assert its `req_ack_o` bit and load its fields into the holding register.
  - Set `last_grant` to that hart.
  - When `free` and no hart is valid, clear `hold_valid`.
  - When not `free`, all acks are 0 and the holding register is unchanged.
- **Requester contract:**
  - A hart holds valid, wren, addr and data stable until it sees ack.
  - It may drop valid only after ack.
  - It may present a new request in the cycle after ack.
- **Fairness:** a continuously valid hart is granted within `N_HARTS` grants.
- **Full buffer:** the entry stalls with `buf_write_o` high; no ack is issued. On the edge where `buf_full_i` falls, the entry is accepted and the next hart is granted in the same cycle, so there are no bubbles.
- **Reset:**
  - `hold_valid` = 0, holding fields = 0.
  - `last_grant` = N_HARTS-1, so hart 0 has first priority.
  - All outputs are 0.
  - Reset asserted mid-stall discards the held request without acking anything new. Its owner was already acked, so the request is lost by design; the system reset covers the harts.

## Timing
- Ack is combinational in the request cycle when the arbiter is free. `buf_write_o` rises the next cycle (1-cycle latency).
- Sustained throughput is 1 request per cycle while `buf_full_i` = 0.
- `buf_*` outputs are registered. `req_ack_o` depends combinationally on `req_valid_i`, `buf_full_i` and state. There is no combinational path from `req_addr_i`/`req_data_i` to any output.
- Wrap-around: the scan index is taken mod `N_HARTS`. After hart N_HARTS-1 is granted, hart 0 has highest priority.

## Configuration
- Macro `HART_ARB_FIXED_PRIORITY_EN`.
- **Defined:** fixed priority, lowest-index valid hart always wins. `last_grant` is not implemented. Starvation of high-index harts is permitted.
- **Undefined (default):** round-robin as described above.

## Test plan
- **Reset:** assert `reset_i` 2 cycles with all harts valid -> all outputs 0, no acks. First cycle after reset grants hart 0, then `buf_write_o`=1 with `buf_hart_o`=0.
- **Round robin:** all 4 harts valid continuously, `buf_full_i`=0 -> acks in order 0,1,2,3,0,1. One `buf_write_o` per cycle. `buf_addr_o` tracks each hart's address.
- **Sparse:** only harts 1 and 3 valid, `last_grant`=3 -> grants 1,3,1,3. Hart 3 with addr 0x3000, wren=1, data 0xDEADBEEF appears unmodified on `buf_*`.
- **Back-pressure:** `buf_full_i`=1 for 5 cycles while held -> `buf_write_o` stays 1, fields stable, no acks. `buf_full_i` falls -> same-cycle ack of the next hart, then its entry on the following cycle.
- **Reset mid-stall:** `buf_full_i`=1, hold_valid=1, pulse `reset_i` -> `buf_write_o`=0 the next cycle and arbitration restarts at hart 0.
- **`HART_ARB_FIXED_PRIORITY_EN` defined:** harts 0 and 2 always valid -> hart 0 granted every cycle, hart 2 never acked.
